// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and block geometry for the cache fill controller
package cache_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, TAG = 2'd2} fill_state_e;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W = $clog2(WORDS_PER_BLOCK);
  localparam int BLOCK_OFFSET_BITS = 4;
endpackage

// File: rtl/fill_counter.sv
// fill_counter: word counter with sync clear, enable, async reset and terminal-count flag
module fill_counter #(
  parameter int W = 4,
  parameter logic [W-1:0] TERMINAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_count = r_cnt;
  assign o_done = r_cnt == TERMINAL;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a missed block from pipelined memory into the data array,
// then writes the tag and releases the stall
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read_enable,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_address,
  output logic [15:0]       cache_data
);
  import cache_pkg::*;
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);
  fill_state_e r_state, w_next;
  logic [ADDR_W-1:0] r_base, w_req_off, w_rsp_off;
  logic [CNT_W-1:0] w_req_cnt, w_rsp_cnt;
  logic w_req_done, w_rsp_last, w_idle, w_fill, w_rsp;
  assign w_idle = r_state == IDLE;
  assign w_fill = r_state == FILL;
  assign w_rsp = w_fill && memory_data_valid;
  // base has a zero block offset, so OR-ing the word offset never carries into the tag
  assign w_req_off = ADDR_W'({w_req_cnt, 1'b0});
  assign w_rsp_off = ADDR_W'({w_rsp_cnt, 1'b0});
  fill_counter #(.W(CNT_W), .TERMINAL(CNT_W'(WORDS_PER_BLOCK))) u_req_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_idle), .i_en(memory_read_enable),
    .o_count(w_req_cnt), .o_done(w_req_done)
  );
  fill_counter #(.W(CNT_W), .TERMINAL(CNT_W'(WORDS_PER_BLOCK - 1))) u_rsp_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_idle), .i_en(w_rsp),
    .o_count(w_rsp_cnt), .o_done(w_rsp_last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_base <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && miss_detected) r_base <= miss_address & BLK_MASK;
    end
  always_comb begin
    w_next = (w_idle && miss_detected) ? FILL :
             (w_rsp && w_rsp_last) ? TAG :
             (r_state == TAG) ? IDLE : r_state;
    fsm_busy = !w_idle;
    memory_read_enable = w_fill && !w_req_done;
    memory_address = memory_read_enable ? (r_base | w_req_off) : '0;
    write_data_array = w_rsp;
    write_tag_array = r_state == TAG;
    cache_address = w_rsp ? (r_base | w_rsp_off) : (fsm_busy ? r_base : '0);
    cache_data = w_rsp ? memory_data : '0;
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed scenarios against a 4-cycle pipelined memory model
module tb_cache_fill_fsm;
  logic clk = 0, rst_n = 1, miss_detected = 0, memory_data_valid = 0;
  logic [15:0] miss_address = 0, memory_data = 0;
  logic fsm_busy, memory_read_enable, write_data_array, write_tag_array;
  logic [15:0] memory_address, cache_address, cache_data;
  int n_cmp = 0, n_bad = 0;
  logic mem_on = 0;
  logic [3:0] pv = 0;
  logic [15:0] pa [4];
  logic [51:0] exp_v;

  cache_fill_fsm dut (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy),
    .memory_read_enable(memory_read_enable), .memory_address(memory_address),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .cache_address(cache_address), .cache_data(cache_data)
  );

  always #5 clk = ~clk;

  function automatic logic [51:0] obs();
    return {fsm_busy, memory_read_enable, memory_address, write_data_array,
            write_tag_array, cache_address, cache_data};
  endfunction

  // expected outputs in fill cycle n for a 4-cycle memory returning data = address
  function automatic logic [51:0] exp_fill(input logic [15:0] b, input int n);
    logic bz, rd, wd, wt;
    logic [15:0] ma, wa, ca;
    bz = n >= 1 && n <= 13;
    rd = n >= 1 && n <= 8;
    wd = n >= 5 && n <= 12;
    wt = n == 13;
    ma = rd ? b + 16'(2 * (n - 1)) : 16'h0;
    wa = wd ? b + 16'(2 * (n - 5)) : 16'h0;
    ca = wd ? wa : (bz ? b : 16'h0);
    return {bz, rd, ma, wd, wt, ca, wa};
  endfunction

  // advance one cycle; the memory model answers each request 4 cycles later
  task automatic tick();
    logic r;
    logic [15:0] a;
    r = memory_read_enable;
    a = memory_address;
    @(posedge clk);
    #1;
    pv = {pv[2:0], r};
    pa[3] = pa[2]; pa[2] = pa[1]; pa[1] = pa[0]; pa[0] = a;
    if (mem_on) begin
      memory_data_valid = pv[3];
      memory_data = pv[3] ? pa[3] : 16'h0;
    end
    #3;
  endtask

  task automatic run_fill(input string name, input logic [15:0] addr, input logic [15:0] base);
    miss_address = addr;
    miss_detected = 1;
    tick();
    miss_detected = 0;
    for (int n = 1; n <= 15; n++) begin
      exp_v = exp_fill(base, n);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %h want %h", name, n, obs(), exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    mem_on = 0;
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    n_cmp++;
    if (obs() !== 52'h0) begin
      n_bad++;
      $display("FAIL reset_assert: got %h want 0", obs());
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 4) rst_n = 1;
      memory_data_valid = 1'($urandom_range(0, 1));
      memory_data = 16'($urandom);
      tick();
      n_cmp++;
      if (obs() !== 52'h0) begin
        n_bad++;
        $display("FAIL reset_idle %0d: got %h want 0", i, obs());
      end
    end
    memory_data_valid = 0;
    memory_data = 0;
  endtask

  task automatic test_basic_fill();
    mem_on = 1;
    run_fill("basic_fill", 16'h1234, 16'h1230);
  endtask

  task automatic test_wrap();
    mem_on = 1;
    run_fill("top_wrap", 16'hFFFF, 16'hFFF0);
  endtask

  task automatic test_irregular();
    int sched [8] = '{2, 4, 7, 8, 11, 13, 14, 17};
    int k = 0, rd_cnt = 0, wr_cnt = 0, tag_cnt = 0;
    logic bz, rd, wd, wt;
    logic [15:0] ma, ca, cd;
    mem_on = 0;
    memory_data_valid = 0;
    miss_address = 16'h4568;
    miss_detected = 1;
    tick();
    miss_detected = 0;
    for (int n = 1; n <= 20; n++) begin
      wd = k < 8 && n == sched[k];
      memory_data_valid = wd;
      memory_data = wd ? 16'hA000 + 16'(k) : 16'h0;
      #1;
      bz = n <= 18;
      rd = n <= 8;
      wt = n == 18;
      ma = rd ? 16'h4560 + 16'(2 * (n - 1)) : 16'h0;
      ca = wd ? 16'h4560 + 16'(2 * k) : (bz ? 16'h4560 : 16'h0);
      cd = wd ? 16'hA000 + 16'(k) : 16'h0;
      exp_v = {bz, rd, ma, wd, wt, ca, cd};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL irregular cycle %0d: got %h want %h", n, obs(), exp_v);
      end
      rd_cnt += int'(memory_read_enable);
      wr_cnt += int'(write_data_array);
      tag_cnt += int'(write_tag_array);
      if (wd) k++;
      tick();
    end
    memory_data_valid = 0;
    n_cmp++;
    if (rd_cnt != 8 || wr_cnt != 8 || tag_cnt != 1) begin
      n_bad++;
      $display("FAIL irregular_counts: got rd=%0d wr=%0d tag=%0d want 8/8/1", rd_cnt, wr_cnt, tag_cnt);
    end
  endtask

  task automatic test_reset_mid_fill();
    mem_on = 1;
    miss_address = 16'h3456;
    miss_detected = 1;
    tick();
    miss_detected = 0;
    for (int n = 1; n <= 5; n++) begin
      exp_v = exp_fill(16'h3450, n);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL midrst_pre cycle %0d: got %h want %h", n, obs(), exp_v);
      end
      tick();
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if (obs() !== 52'h0) begin
      n_bad++;
      $display("FAIL midrst_async: got %h want 0", obs());
    end
    tick();
    rst_n = 1;
    for (int n = 7; n <= 14; n++) begin
      n_cmp++;
      if (obs() !== 52'h0) begin
        n_bad++;
        $display("FAIL midrst_late cycle %0d: got %h want 0", n, obs());
      end
      tick();
    end
    run_fill("after_reset", 16'h0040, 16'h0040);
  endtask

  task automatic test_back_to_back();
    mem_on = 1;
    miss_address = 16'h1234;
    miss_detected = 1;
    tick();
    for (int n = 1; n <= 13; n++) begin
      exp_v = exp_fill(16'h1230, n);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL held_miss cycle %0d: got %h want %h", n, obs(), exp_v);
      end
      if (n == 13) miss_address = 16'h2000;
      tick();
    end
    n_cmp++;
    if (obs() !== 52'h0) begin
      n_bad++;
      $display("FAIL b2b_idle: got %h want 0", obs());
    end
    tick();
    miss_detected = 0;
    for (int n = 1; n <= 15; n++) begin
      exp_v = exp_fill(16'h2000, n);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL b2b_fill cycle %0d: got %h want %h", n, obs(), exp_v);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pa[i] = 16'h0;
    test_reset();
    test_basic_fill();
    test_wrap();
    test_irregular();
    test_reset_mid_fill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller for the direct-mapped cache; it is the responder to the cache's `cache_miss` output. On a miss it fetches the full 8-word (16-byte) block from the 4-cycle pipelined main memory and writes each returned word into the data array. It then writes the tag to the metadata array and releases the pipeline stall. One instance sits beside each cache (I-cache and D-cache).

## Interface
Parameters:
- `WORDS_PER_BLOCK`, 8: words per cache block; must be a power of two.
- `ADDR_W`, 16: byte-address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `miss_detected`  in  1  the cache reports a miss for `miss_address`; level, held until `fsm_busy` drops.
- `miss_address`  in  16  byte address that missed.
- `memory_data`  in  16  read data returned from main memory.
- `memory_data_valid`  in  1  `memory_data` is valid this cycle; responses return in request order.
- `fsm_busy`  out  1  a fill is in progress; the pipeline stalls on it.
- `memory_read_enable`  out  1  issue a read of `memory_address` this cycle.
- `memory_address`  out  16  word-aligned address of the current memory request.
- `write_data_array`  out  1  drives the cache `data_write` input.
- `write_tag_array`  out  1  drives the cache `tag_write` input.
- `cache_address`  out  16  address presented to the cache during the fill.
- `cache_data`  out  16  word written into the data array.

## Operation
- States: IDLE, FILL, TAG.
- Reset (asynchronous) forces IDLE. Both counters clear to 0 and `base` clears to 0. Every output is 0 during and after reset until a miss is accepted.
- IDLE:
  - If `miss_detected` is 1 at a clock edge, latch `base = {miss_address[15:4], 4'b0}` (bits 3:0, including bit 0, are ignored), clear `req_cnt` and `rsp_cnt`, and go to FILL.
  - `memory_data_valid` is ignored in IDLE.
- FILL, request side:
  - While `req_cnt < 8`: `memory_read_enable = 1` and `memory_address = base + {req_cnt, 1'b0}`.
  - `req_cnt` increments each cycle. One request is issued per cycle, with no backpressure.
  - At `req_cnt == 8`, `memory_read_enable` is 0.
- FILL, response side:
  - In any FILL cycle with `memory_data_valid = 1`: `write_data_array = 1`, `cache_address = base + {rsp_cnt, 1'b0}`, `cache_data = memory_data`, and `rsp_cnt` increments.
  - On the response with `rsp_cnt == 7`, go to TAG.
  - In FILL cycles without a response: `write_data_array = 0` and `cache_address = base`.
- TAG:
  - `write_tag_array = 1` and `cache_address = base` for exactly one cycle, then go to IDLE.
- `fsm_busy = 1` in FILL and TAG, and 0 in IDLE.
- Word offsets wrap inside the block only. The base 0xFFF0 yields addresses 0xFFF0 to 0xFFFE, with no carry into the tag bits.
- `miss_detected` is ignored while busy. A still-asserted `miss_detected` in the IDLE cycle after TAG starts a new fill; by then the cache normally reports a hit.
- Reset mid-fill:
  - Abandon the fill immediately. No tag write occurs.
  - Memory responses still in flight after reset are ignored, because the block is in IDLE.
- `memory_data_valid` arriving while `req_cnt < 8` is legal. The request and response sides run concurrently.

## Timing
- All outputs are combinational from state, counters, `base` and current inputs. The FSM has no registered outputs.
- The miss is accepted at edge E0. The cycle after E0 is fill cycle 1.
- Requests go out in cycles 1–8. With the 4-cycle memory, data is valid in cycles 5–12.
- TAG occurs in cycle 13 and IDLE resumes in cycle 14. `fsm_busy` is high for 13 cycles.
- Latency from the first request to the tag write is set by the memory, not the FSM. The FSM waits for exactly 8 valid responses, however late they arrive.

## Structure
- Shared package `cache_pkg`:
  - state encoding (IDLE = 2'd0, FILL = 2'd1, TAG = 2'd2)
  - `WORDS_PER_BLOCK`
  - `OFFSET_W = $clog2(WORDS_PER_BLOCK)`
  - `BLOCK_OFFSET_BITS = 4`
- One sub-module, `fill_counter`: a 4-bit counter with synchronous clear, enable and asynchronous reset, plus a `done` output at the terminal count. It is instantiated twice, for `req_cnt` and `rsp_cnt`.

## Test plan
- Reset and idle: assert `rst_n = 0` mid-cycle, then apply `miss_detected = 0` and random `memory_data_valid` → all outputs 0; no writes.
- Basic fill: miss at 0x1234 with the 4-cycle memory model returning `data = address` → requests to 0x1230–0x123E in cycles 1–8. Data writes in cycles 5–12 with `cache_data` 0x1230–0x123E. `write_tag_array` pulses in cycle 13 with `cache_address = 0x1230`. `fsm_busy` is high for cycles 1–13 only.
- Top-of-memory wrap: miss at 0xFFFF → addresses 0xFFF0–0xFFFE, no carry into the tag bits, tag written at 0xFFF0.
- Irregular memory: valid responses spaced 1–3 cycles apart → exactly 8 data writes in order, then one tag write. `memory_read_enable` never exceeds 8 pulses.
- Reset mid-fill: deassert `rst_n` in cycle 6, then release it → outputs go to 0 asynchronously. The late valid responses produce no writes and there is no tag write. A subsequent miss at 0x0040 fills correctly.
- Held miss and back-to-back misses: `miss_detected` held through the whole fill, then the address changes to 0x2000 → the 0x2000 fill starts in the cycle after IDLE is re-entered. No second fill of the old block occurs unless the miss is still asserted.
